i2s_mic_transmitter: RTL and testbench

//   I2S responder (slave) transmitter: the far end of an INMP441-style mic

---
 rtl/i2s_mic_transmitter.sv | 144 ++++++++++++++
 tb/tb_i2s_mic_transmitter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_mic_transmitter.sv
// I2S responder transmitter. It drives one 24-bit channel slot onto sd using
// the master's sck/ws, which arrive asynchronously to clk. Samples come in
// through a 1-entry valid/ready buffer.
module i2s_mic_transmitter #(
  parameter int w_sample = 24,
  parameter int w_slot   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [w_sample-1:0] sample,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic                sck,
  input  logic                ws,
  input  logic                lr,
  output logic                sd,
  output logic                sd_oe,
  output logic                frame_start,
  output logic                underrun
);

  localparam int bw = $clog2(w_sample);
  localparam logic [bw-1:0] last_bit = bw'(w_sample - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DELAY = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;

  if (w_slot <= w_sample) begin : g_bad_slot
    $error("w_slot must exceed w_sample");
  end

  logic [1:0]          sck_s;
  logic [1:0]          ws_s;
  logic                sck_d;
  logic                fall;
  logic                ws_now;
  logic                ws_prev;
  logic                ws_seen;
  logic                ws_edge;
  logic                mine;
  logic [1:0]          state;
  logic [bw-1:0]       bitcnt;
  // Remaining bits after the MSB; the MSB goes straight from the buffer to sd.
  logic [w_sample-2:0] rest;
  logic                full;
  logic [w_sample-1:0] hold_reg;
  logic                consume;

  // Two-flop synchronisers for sck and ws, plus the delayed sck for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_s <= '0;
      ws_s  <= '0;
      sck_d <= 1'b0;
    end else begin
      sck_s <= {sck_s[0], sck};
      ws_s  <= {ws_s[0], ws};
      sck_d <= sck_s[1];
    end
  end

  assign fall    = sck_d & ~sck_s[1];
  assign ws_now  = ws_s[1];
  assign mine    = (ws_now == lr);
  // The first fall after reset only records ws, so a slot starts only on a
  // genuine ws transition into our channel.
  assign ws_edge = ws_seen & (ws_now != ws_prev);
  assign consume = fall & (state == DELAY) & ~ws_edge & full;

  assign sample_ready = ~full;

  // One-entry sample buffer: filled by the handshake, emptied when a slot starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full     <= 1'b0;
      hold_reg <= '0;
    end else if (consume) begin
      full <= 1'b0;
    end else if (sample_valid && !full) begin
      hold_reg <= sample;
      full     <= 1'b1;
    end
  end

  // Slot sequencer: acts once per synchronised sck falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bitcnt      <= '0;
      rest        <= '0;
      sd          <= 1'b0;
      sd_oe       <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      ws_prev     <= 1'b0;
      ws_seen     <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      if (fall) begin
        ws_prev <= ws_now;
        ws_seen <= 1'b1;
        case (state)
          IDLE: begin
            if (ws_edge && mine) state <= DELAY;
          end
          DELAY: begin
            if (ws_edge) begin
              sd    <= 1'b0;
              sd_oe <= 1'b0;
              state <= mine ? DELAY : IDLE;
            end else begin
              rest        <= full ? hold_reg[w_sample-2:0] : '0;
              sd          <= full ? hold_reg[w_sample-1] : 1'b0;
              sd_oe       <= 1'b1;
              frame_start <= 1'b1;
              underrun    <= ~full;
              bitcnt      <= '0;
              state       <= SHIFT;
            end
          end
          SHIFT: begin
            if (ws_edge) begin
              sd    <= 1'b0;
              sd_oe <= 1'b0;
              state <= mine ? DELAY : IDLE;
            end else if (bitcnt == last_bit) begin
              sd    <= 1'b0;
              sd_oe <= 1'b0;
              state <= IDLE;
            end else begin
              sd     <= rest[w_sample-2];
              rest   <= rest << 1;
              bitcnt <= bitcnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2s_mic_transmitter.sv
// Bench for i2s_mic_transmitter: an I2S master drives sck/ws, a feeder pushes
// samples through valid/ready, and a receiver monitor reassembles each slot
// and compares it with the expected-slot queue.
module tb_i2s_mic_transmitter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] sample;
  logic        sample_valid;
  logic        sample_ready;
  logic        sck;
  logic        ws;
  logic        lr;
  logic        sd;
  logic        sd_oe;
  logic        frame_start;
  logic        underrun;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [23:0] data;
    logic        uf;
    logic        chk;
  } exp_t;

  exp_t        expq[$];
  logic [23:0] loadq[$];

  i2s_mic_transmitter #(.w_sample(24), .w_slot(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sck          (sck),
    .ws           (ws),
    .lr           (lr),
    .sd           (sd),
    .sd_oe        (sd_oe),
    .frame_start  (frame_start),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Pulse counters, sampled away from the active clock edge.
  int fs_cnt = 0;
  int uf_cnt = 0;
  always @(negedge clk) begin
    if (frame_start === 1'b1) fs_cnt++;
    if (underrun === 1'b1) uf_cnt++;
  end

  // Sample feeder: presents queued samples with valid held until accepted.
  initial begin
    logic hs;
    int   wcnt;
    sample_valid = 1'b0;
    sample       = '0;
    wcnt         = 0;
    forever begin
      @(posedge clk);
      hs = sample_valid && sample_ready;
      @(negedge clk);
      if (hs) sample_valid = 1'b0;
      if (sample_valid) begin
        wcnt++;
        if (wcnt > 4000) begin
          checks++;
          errors++;
          $display("FAIL feeder_timeout actual=ready_low required=accept sample=%h", sample);
          sample_valid = 1'b0;
        end
      end else if (loadq.size() > 0) begin
        sample       = loadq.pop_front();
        sample_valid = 1'b1;
        wcnt         = 0;
      end
    end
  end

  // Receiver monitor: a slot is the run of sck rises with constant ws.
  logic        last_ws;
  logic        active;
  logic        ours;
  int          pos;
  logic [23:0] rx;
  logic [31:0] oev;
  int          fs0;
  int          uf0;

  task automatic finish_slot(input int len);
    int          n;
    exp_t        e;
    logic [31:0] oe_req;
    logic [23:0] d_req;
    n = (len - 1 < 24) ? len - 1 : 24;
    if (!ours) begin
      check("other_slot_oe", oev, 32'h0);
      check("other_slot_frame_start", fs_cnt - fs0, 0);
      check("other_slot_underrun", uf_cnt - uf0, 0);
    end else if (expq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL slot_unexpected actual=slot_seen required=no_slot");
    end else begin
      e = expq.pop_front();
      if (e.chk) begin
        oe_req = '0;
        for (int i = 1; i <= n; i++) oe_req[i] = 1'b1;
        d_req = e.uf ? 24'h0 : (e.data >> (24 - n));
        check("slot_data", rx, d_req);
        check("slot_oe", oev, oe_req);
        check("slot_frame_start", fs_cnt - fs0, 1);
        check("slot_underrun", uf_cnt - uf0, {31'h0, e.uf});
      end
    end
  endtask

  initial begin
    active  = 1'b0;
    last_ws = 1'b1;
    ours    = 1'b0;
    pos     = 0;
    rx      = '0;
    oev     = '0;
    fs0     = 0;
    uf0     = 0;
    forever begin
      @(posedge sck);
      #1;
      if (ws !== last_ws) begin
        if (active) finish_slot(pos + 1);
        active  = 1'b1;
        ours    = (ws === lr);
        pos     = 0;
        rx      = '0;
        oev     = '0;
        fs0     = fs_cnt;
        uf0     = uf_cnt;
        last_ws = ws;
      end else begin
        pos++;
      end
      if (pos < 32) oev[pos] = sd_oe;
      if (pos >= 1 && pos <= 24) rx = {rx[22:0], sd};
    end
  end

  task automatic push_load(input logic [23:0] d, input logic chk);
    exp_t e;
    e.data = d;
    e.uf   = 1'b0;
    e.chk  = chk;
    loadq.push_back(d);
    expq.push_back(e);
  endtask

  task automatic push_underrun();
    exp_t e;
    e.data = '0;
    e.uf   = 1'b1;
    e.chk  = 1'b1;
    expq.push_back(e);
  endtask

  // Directed schedule, applied just before the sck fall of slot s, bit b.
  task automatic hook(input int s, input int b);
    if (s == 0 && b == 2) push_load(24'hA5C3F0, 1'b1);
    if (s == 2 && b == 2) push_underrun();
    if (s == 4 && b == 2) begin
      push_load(24'h000001, 1'b1);
      push_load(24'h000002, 1'b1);
      push_load(24'h000003, 1'b1);
    end
    if (s == 9 && b == 28) begin
      lr = 1'b1;
      push_load(24'h800001, 1'b1);
    end
    if (s == 11 && b == 2) push_load(24'h123456, 1'b1);
    if (s == 12 && b == 5) push_load(24'h654321, 1'b1);
    if (s == 15 && b == 2) push_load(24'h111111, 1'b0);
    if (s == 16 && b == 5) loadq.push_back(24'h0F0F0F);
    if (s == 16 && b == 8) begin
      check("pre_reset_oe", {31'h0, sd_oe}, 32'h1);
      check("pre_reset_ready", {31'h0, sample_ready}, 32'h0);
      rst_n = 1'b0;
      #1;
      check("async_reset_oe", {31'h0, sd_oe}, 32'h0);
      check("async_reset_ready", {31'h0, sample_ready}, 32'h1);
      #20;
      rst_n = 1'b1;
    end
    if (s == 17 && b == 2) push_load(24'hABCDEF, 1'b1);
    if (s == 19 && b == 2) push_underrun();
  endtask

  // I2S master: ws changes on the sck falling edge, slot 12 is cut short.
  initial begin
    int len;
    sck   = 1'b1;
    ws    = 1'b1;
    lr    = 1'b0;
    rst_n = 1'b0;
    #23;
    check("reset_ready", {31'h0, sample_ready}, 32'h1);
    check("reset_oe", {31'h0, sd_oe}, 32'h0);
    check("reset_sd", {31'h0, sd}, 32'h0);
    check("reset_frame_start", {31'h0, frame_start}, 32'h0);
    check("reset_underrun", {31'h0, underrun}, 32'h0);
    rst_n = 1'b1;
    for (int s = 0; s < 22; s++) begin
      len = (s == 12) ? 11 : 32;
      for (int b = 0; b < len; b++) begin
        hook(s, b);
        sck = 1'b0;
        if (b == 0) ws = (s % 2 == 0);
        #80;
        sck = 1'b1;
        #80;
      end
    end
    #200;
    check("expected_slots_left", expq.size(), 0);
    check("loads_left", loadq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
